// File: rtl/dp_pkg.sv
// Encodings shared between the datapath and the StateController: writeback mux,
// register select, shifter and ALU operations.
package dp_pkg;

  localparam int DP_DATA_W = 16;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [2:0] NSEL_RN = 3'b001;
  localparam logic [2:0] NSEL_RM = 3'b010;
  localparam logic [2:0] NSEL_RD = 3'b100;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

endpackage

// File: rtl/dp_regfile.sv
// NREGS x DATA_W register file: one combinational read port, one write port on clk edge.
// Read returns the pre-edge value on a same-cycle write; no backpressure.
module dp_regfile #(
  parameter  int DATA_W = 16,
  parameter  int NREGS  = 8,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [REG_AW-1:0] rd_idx,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_idx] = wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_dat = regs_q[rd_idx];

endmodule

// File: rtl/simple_datapath.sv
// Controller-driven datapath: regfile -> A/B -> shifter/ALU -> C and {V,N,Z} status.
// One cycle per stage (read->A/B, A/B->C/status, C->regfile); strobe driven, no backpressure.
module simple_datapath
  import dp_pkg::*;
#(
  parameter  int DATA_W = DP_DATA_W,
  parameter  int NREGS  = 8,
  parameter  int PC_W   = 8,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [2:0]        nsel,
  input  logic [1:0]        vsel,
  input  logic              loada,
  input  logic              loadb,
  input  logic              loadc,
  input  logic              loads,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  input  logic [REG_AW-1:0] rd,
  input  logic [1:0]        shift,
  input  logic [1:0]        alu_op,
  input  logic              asel,
  input  logic              bsel,
  input  logic [DATA_W-1:0] sximm8,
  input  logic [DATA_W-1:0] sximm5,
  input  logic [DATA_W-1:0] mdata,
  input  logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] datapath_out,
  output logic [2:0]        status
);

  logic [REG_AW-1:0] reg_idx;
  logic              idx_vld;
  logic              rf_wr_en;
  logic [DATA_W-1:0] wb_dat;
  logic [DATA_W-1:0] rf_rd_dat;

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic [2:0]        status_q, status_d;

  logic [DATA_W-1:0] b_shifted;
  logic [DATA_W-1:0] ain, bin;
  logic [DATA_W-1:0] alu_res;
  logic              alu_v;
  alu_op_e           op_e;
  shift_e            sh_e;

  assign op_e = alu_op_e'(alu_op);
  assign sh_e = shift_e'(shift);

  // A malformed nsel reads index 0 and must never write anywhere.
  always_comb begin
    reg_idx = '0;
    idx_vld = 1'b0;
    case (nsel)
      NSEL_RN: begin reg_idx = rn; idx_vld = 1'b1; end
      NSEL_RM: begin reg_idx = rm; idx_vld = 1'b1; end
      NSEL_RD: begin reg_idx = rd; idx_vld = 1'b1; end
      default: begin reg_idx = '0; idx_vld = 1'b0; end
    endcase
  end

  assign rf_wr_en = write & idx_vld;

  always_comb begin
    wb_dat = c_q;
    case (vsel)
      VSEL_C:     wb_dat = c_q;
      VSEL_PC:    wb_dat = {{(DATA_W-PC_W){1'b0}}, pc};
      VSEL_IMM:   wb_dat = sximm8;
      VSEL_MDATA: wb_dat = mdata;
      default:    wb_dat = c_q;
    endcase
  end

  dp_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (rf_wr_en),
    .wr_idx (reg_idx),
    .wr_dat (wb_dat),
    .rd_idx (reg_idx),
    .rd_dat (rf_rd_dat)
  );

  always_comb begin
    b_shifted = b_q;
    case (sh_e)
      SH_NONE: b_shifted = b_q;
      SH_LSL:  b_shifted = {b_q[DATA_W-2:0], 1'b0};
      SH_LSR:  b_shifted = {1'b0, b_q[DATA_W-1:1]};
      SH_ASR:  b_shifted = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
      default: b_shifted = b_q;
    endcase
  end

  assign ain = asel ? '0 : a_q;
  assign bin = bsel ? sximm5 : b_shifted;

  // Overflow: operands that agree in sign (after the subtrahend's sign flip)
  // produce a result of the opposite sign.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (op_e)
      ALU_ADD: begin
        alu_res = ain + bin;
        alu_v   = (ain[DATA_W-1] == bin[DATA_W-1]) && (alu_res[DATA_W-1] != ain[DATA_W-1]);
      end
      ALU_SUB: begin
        alu_res = ain - bin;
        alu_v   = (ain[DATA_W-1] != bin[DATA_W-1]) && (alu_res[DATA_W-1] != ain[DATA_W-1]);
      end
      ALU_AND: alu_res = ain & bin;
      ALU_NOT: alu_res = ~bin;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    a_d      = loada ? rf_rd_dat : a_q;
    b_d      = loadb ? rf_rd_dat : b_q;
    c_d      = loadc ? alu_res : c_q;
    status_d = loads ? {alu_v, alu_res[DATA_W-1], (alu_res == '0)} : status_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      status_q <= status_d;
    end
  end

  assign datapath_out = c_q;
  assign status       = status_q;

endmodule

// File: tb/tb_simple_datapath.sv
// Directed bench for simple_datapath: each task drives one scenario and checks
// datapath_out/status against hand-computed values.
module tb_simple_datapath;
  import dp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  nsel, rn, rm, rd;
  logic [1:0]  vsel, shift, alu_op;
  logic [15:0] sximm8, sximm5, mdata;
  logic [7:0]  pc;
  logic [15:0] datapath_out;
  logic [2:0]  status;

  int n_checks = 0;
  int n_pass   = 0;

  simple_datapath dut (
    .clk(clk), .rst_n(rst_n), .write(write), .nsel(nsel), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .rn(rn), .rm(rm), .rd(rd), .shift(shift), .alu_op(alu_op),
    .asel(asel), .bsel(bsel), .sximm8(sximm8), .sximm5(sximm5),
    .mdata(mdata), .pc(pc), .datapath_out(datapath_out), .status(status)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write = 0; loada = 0; loadb = 0; loadc = 0; loads = 0;
    asel = 0; bsel = 0; nsel = 3'b000; vsel = VSEL_C;
    rn = 0; rm = 0; rd = 0; shift = SH_NONE; alu_op = ALU_ADD;
    sximm8 = 0; sximm5 = 0; mdata = 0; pc = 0;
  endtask

  task automatic wr_reg(input logic [2:0] idx, input logic [15:0] val);
    nsel = NSEL_RD; rd = idx; vsel = VSEL_IMM; sximm8 = val; write = 1;
    tick();
    idle();
  endtask

  task automatic ld_a(input logic [2:0] idx);
    nsel = NSEL_RN; rn = idx; loada = 1;
    tick();
    idle();
  endtask

  task automatic ld_b(input logic [2:0] idx);
    nsel = NSEL_RM; rm = idx; loadb = 1;
    tick();
    idle();
  endtask

  task automatic exec(input logic [1:0] op, input logic [1:0] sh, input logic as,
                      input logic bs, input logic [15:0] imm5, input logic lc, input logic ls);
    alu_op = op; shift = sh; asel = as; bsel = bs; sximm5 = imm5; loadc = lc; loads = ls;
    tick();
    idle();
  endtask

  // Routes a register through A and the ALU (A + 0) into C.
  task automatic read_reg(input logic [2:0] idx, output logic [15:0] val);
    ld_a(idx);
    exec(ALU_ADD, SH_NONE, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    val = datapath_out;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    idle();
    rst_n = 0;
    #2;
    n_checks++; if (datapath_out !== 16'h0) $display("FAIL reset_out got=%h exp=0000", datapath_out); else n_pass++;
    n_checks++; if (status !== 3'b000) $display("FAIL reset_status got=%b exp=000", status); else n_pass++;
    tick(); tick();
    rst_n = 1;
    tick();
    read_reg(3'd5, v);
    n_checks++; if (v !== 16'h0) $display("FAIL reset_r5 got=%h exp=0000", v); else n_pass++;
  endtask

  task automatic test_write_imm();
    wr_reg(3'd3, 16'd42);
    ld_a(3'd3);
    exec(ALU_ADD, SH_NONE, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    n_checks++; if (datapath_out !== 16'd42) $display("FAIL write_imm_r3 got=%h exp=002a", datapath_out); else n_pass++;
    n_checks++; if (status !== 3'b000) $display("FAIL write_imm_status got=%b exp=000", status); else n_pass++;
  endtask

  task automatic test_add();
    wr_reg(3'd1, 16'd5);
    wr_reg(3'd2, 16'd3);
    ld_a(3'd1);
    ld_b(3'd2);
    exec(ALU_ADD, SH_NONE, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    n_checks++; if (datapath_out !== 16'd8) $display("FAIL add_out got=%h exp=0008", datapath_out); else n_pass++;
    n_checks++; if (status !== 3'b000) $display("FAIL add_status got=%b exp=000", status); else n_pass++;
  endtask

  task automatic test_sub_zero();
    wr_reg(3'd5, 16'h1234);
    ld_a(3'd5);
    ld_b(3'd5);
    exec(ALU_SUB, SH_NONE, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    n_checks++; if (status !== 3'b001) $display("FAIL sub_zero_status got=%b exp=001", status); else n_pass++;
    n_checks++; if (datapath_out !== 16'd8) $display("FAIL sub_c_held got=%h exp=0008", datapath_out); else n_pass++;
  endtask

  task automatic test_overflow();
    wr_reg(3'd6, 16'h7FFF);
    ld_a(3'd6);
    exec(ALU_ADD, SH_NONE, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1);
    n_checks++; if (datapath_out !== 16'h8000) $display("FAIL add_ovf_out got=%h exp=8000", datapath_out); else n_pass++;
    n_checks++; if (status !== 3'b110) $display("FAIL add_ovf_status got=%b exp=110", status); else n_pass++;
    wr_reg(3'd7, 16'h8000);
    ld_a(3'd7);
    exec(ALU_SUB, SH_NONE, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1);
    n_checks++; if (datapath_out !== 16'h7FFF) $display("FAIL sub_ovf_out got=%h exp=7fff", datapath_out); else n_pass++;
    n_checks++; if (status !== 3'b100) $display("FAIL sub_ovf_status got=%b exp=100", status); else n_pass++;
    exec(ALU_AND, SH_NONE, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    n_checks++; if (status !== 3'b010) $display("FAIL and_status got=%b exp=010", status); else n_pass++;
  endtask

  task automatic test_shift_alu();
    wr_reg(3'd1, 16'h8001);
    ld_b(3'd1);
    exec(ALU_ADD, SH_ASR, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    n_checks++; if (datapath_out !== 16'hC000) $display("FAIL shift_asr got=%h exp=c000", datapath_out); else n_pass++;
    exec(ALU_ADD, SH_LSR, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    n_checks++; if (datapath_out !== 16'h4000) $display("FAIL shift_lsr got=%h exp=4000", datapath_out); else n_pass++;
    exec(ALU_ADD, SH_LSL, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    n_checks++; if (datapath_out !== 16'h0002) $display("FAIL shift_lsl got=%h exp=0002", datapath_out); else n_pass++;
    exec(ALU_ADD, SH_NONE, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    n_checks++; if (datapath_out !== 16'h8001) $display("FAIL shift_none got=%h exp=8001", datapath_out); else n_pass++;
    exec(ALU_ADD, SH_LSL, 1'b1, 1'b1, 16'h0003, 1'b1, 1'b0);
    n_checks++; if (datapath_out !== 16'h0003) $display("FAIL shift_bypass got=%h exp=0003", datapath_out); else n_pass++;
    wr_reg(3'd2, 16'h00FF);
    wr_reg(3'd0, 16'h0F0F);
    ld_b(3'd2);
    ld_a(3'd0);
    exec(ALU_NOT, SH_NONE, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    n_checks++; if (datapath_out !== 16'hFF00) $display("FAIL not_out got=%h exp=ff00", datapath_out); else n_pass++;
    n_checks++; if (status !== 3'b010) $display("FAIL not_status got=%b exp=010", status); else n_pass++;
    exec(ALU_AND, SH_NONE, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    n_checks++; if (datapath_out !== 16'h000F) $display("FAIL and_out got=%h exp=000f", datapath_out); else n_pass++;
  endtask

  task automatic test_vsel();
    logic [15:0] v;
    nsel = NSEL_RD; rd = 3'd2; vsel = VSEL_PC; pc = 8'hA5; write = 1;
    tick(); idle();
    read_reg(3'd2, v);
    n_checks++; if (v !== 16'h00A5) $display("FAIL vsel_pc got=%h exp=00a5", v); else n_pass++;
    nsel = NSEL_RD; rd = 3'd3; vsel = VSEL_MDATA; mdata = 16'hBEEF; write = 1;
    tick(); idle();
    read_reg(3'd3, v);
    n_checks++; if (v !== 16'hBEEF) $display("FAIL vsel_mdata got=%h exp=beef", v); else n_pass++;
    // C now holds 0xBEEF; write it back into R4 and read it out again.
    nsel = NSEL_RD; rd = 3'd4; vsel = VSEL_C; write = 1;
    tick(); idle();
    exec(ALU_NOT, SH_NONE, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    read_reg(3'd4, v);
    n_checks++; if (v !== 16'hBEEF) $display("FAIL vsel_c got=%h exp=beef", v); else n_pass++;
  endtask

  task automatic test_nsel_invalid();
    logic [15:0] v;
    wr_reg(3'd0, 16'h1111);
    wr_reg(3'd1, 16'h2222);
    nsel = 3'b011; rd = 3'd1; rn = 3'd1; vsel = VSEL_IMM; sximm8 = 16'h5555; write = 1;
    tick(); idle();
    nsel = 3'b000; rd = 3'd1; vsel = VSEL_IMM; sximm8 = 16'h6666; write = 1;
    tick(); idle();
    nsel = 3'b110; rn = 3'd1; loada = 1;
    tick(); idle();
    exec(ALU_ADD, SH_NONE, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    n_checks++; if (datapath_out !== 16'h1111) $display("FAIL nsel_bad_read got=%h exp=1111", datapath_out); else n_pass++;
    read_reg(3'd1, v);
    n_checks++; if (v !== 16'h2222) $display("FAIL nsel_bad_wr_r1 got=%h exp=2222", v); else n_pass++;
    read_reg(3'd0, v);
    n_checks++; if (v !== 16'h1111) $display("FAIL nsel_bad_wr_r0 got=%h exp=1111", v); else n_pass++;
  endtask

  task automatic test_hold();
    exec(ALU_SUB, SH_NONE, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b1);
    alu_op = ALU_ADD; asel = 1; bsel = 1; sximm5 = 16'h0005;
    repeat (3) tick();
    idle();
    n_checks++; if (datapath_out !== 16'hFFFF) $display("FAIL hold_out got=%h exp=ffff", datapath_out); else n_pass++;
    n_checks++; if (status !== 3'b010) $display("FAIL hold_status got=%b exp=010", status); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    #3;
    rst_n = 0;
    #1;
    n_checks++; if (datapath_out !== 16'h0) $display("FAIL mid_reset_out got=%h exp=0000", datapath_out); else n_pass++;
    n_checks++; if (status !== 3'b000) $display("FAIL mid_reset_status got=%b exp=000", status); else n_pass++;
    nsel = NSEL_RD; rd = 3'd3; vsel = VSEL_IMM; sximm8 = 16'h0077; write = 1;
    loadc = 1; loads = 1; asel = 1; bsel = 1; sximm5 = 16'h8000;
    tick();
    n_checks++; if (datapath_out !== 16'h0 || status !== 3'b000)
      $display("FAIL reset_vs_strobes got=%h/%b exp=0000/000", datapath_out, status); else n_pass++;
    idle();
    #2 rst_n = 1;
    tick();
    read_reg(3'd3, v);
    n_checks++; if (v !== 16'h0) $display("FAIL mid_reset_r3 got=%h exp=0000", v); else n_pass++;
  endtask

  task automatic test_same_edge();
    logic [15:0] v;
    nsel = NSEL_RD; rd = 3'd4; vsel = VSEL_IMM; sximm8 = 16'd7; write = 1; loada = 1;
    tick(); idle();
    exec(ALU_ADD, SH_NONE, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    n_checks++; if (datapath_out !== 16'h0) $display("FAIL same_edge_a got=%h exp=0000", datapath_out); else n_pass++;
    read_reg(3'd4, v);
    n_checks++; if (v !== 16'd7) $display("FAIL same_edge_r4 got=%h exp=0007", v); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_imm();
    test_add();
    test_sub_zero();
    test_overflow();
    test_shift_alu();
    test_vsel();
    test_nsel_invalid();
    test_hold();
    test_reset_mid();
    test_same_edge();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
